// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states, size helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane steering: extract+extend for loads, byte-lane merge for stores.
// Purely combinational; shift is the byte offset within the doubleword times 8.
module lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
)(
   input  logic [DATA_WIDTH-1:0] i_word,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [1:0]            i_size,
   input  logic                  i_signed,
   input  logic [2:0]            i_off,
   output logic [DATA_WIDTH-1:0] o_load,
   output logic [DATA_WIDTH-1:0] o_merge
);

   logic [5:0]            w_shift;
   logic [DATA_WIDTH-1:0] w_lanes;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_mask_sh;

   assign w_shift = {i_off, 3'b000};
   assign w_lanes = i_word >> w_shift;

   always_comb begin
      w_mask = '1;
      o_load = w_lanes;
      case (size_e'(i_size))
         SIZE_B: begin
            w_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
            o_load = {{(DATA_WIDTH-8){i_signed & w_lanes[7]}}, w_lanes[7:0]};
         end
         SIZE_H: begin
            w_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
            o_load = {{(DATA_WIDTH-16){i_signed & w_lanes[15]}}, w_lanes[15:0]};
         end
         SIZE_W: begin
            w_mask = {{(DATA_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};
            o_load = {{(DATA_WIDTH-32){i_signed & w_lanes[31]}}, w_lanes[31:0]};
         end
         SIZE_D: begin
            w_mask = '1;
            o_load = w_lanes;
         end
      endcase
   end

   // Untouched bytes pass through from the sampled doubleword bit-exactly.
   assign w_mask_sh = w_mask << w_shift;
   assign o_merge   = (i_word & ~w_mask_sh) | ((i_wdata << w_shift) & w_mask_sh);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory; one request in flight, RMW for sub-dword stores.
// Latency after acceptance: load W+1, dword store 2, sub-dword store W+2, error 1; no response backpressure.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 64,
   parameter int MEM_INDEX_WIDTH = 6,
   parameter int WAIT_CYCLES     = 2
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_error,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_e                r_state;
   logic [3:0]            r_cnt;
   logic                  r_ready;
   logic                  r_write;
   logic                  r_signed;
   logic [1:0]            r_size;
   logic [2:0]            r_off;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_resp_valid;
   logic                  r_resp_error;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [DATA_WIDTH-1:0] r_mem_write_data;

   logic                  w_accept;
   logic [3:0]            w_nbytes;
   logic                  w_misalign;
   logic                  w_range;
   logic [ADDR_WIDTH-1:0] w_index;
   logic [DATA_WIDTH-1:0] w_load;
   logic [DATA_WIDTH-1:0] w_merge;

   // Gated by reset so the unit shows not-ready for the whole reset window.
   assign req_ready  = r_ready & ~reset;
   assign w_accept   = req_valid & req_ready;
   assign w_nbytes   = size_bytes(req_size);
   assign w_misalign = |({1'b0, req_addr[2:0]} & (w_nbytes - 4'd1));
   assign w_range    = |req_addr[ADDR_WIDTH-1:3+MEM_INDEX_WIDTH];
   assign w_index    = {3'b000, req_addr[ADDR_WIDTH-1:3]};

   lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
      .i_word   (mem_read_data),
      .i_wdata  (r_wdata),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_off    (r_off),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_ready          <= 1'b1;
         r_write          <= 1'b0;
         r_signed         <= 1'b0;
         r_size           <= '0;
         r_off            <= '0;
         r_wdata          <= '0;
         r_resp_valid     <= 1'b0;
         r_resp_error     <= 1'b0;
         r_resp_rdata     <= '0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_write       <= req_write;
                  r_signed      <= req_signed;
                  r_size        <= req_size;
                  r_off         <= req_addr[2:0];
                  r_wdata       <= req_wdata;
                  r_mem_address <= w_index;
                  r_ready       <= 1'b0;
                  r_cnt         <= '0;
                  if (w_misalign || w_range) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_error <= 1'b1;
                  end else if (req_write && req_size == SIZE_D) begin
                     r_state          <= ST_WR;
                     r_mem_write      <= 1'b1;
                     r_mem_write_data <= req_wdata;
                  end else begin
                     r_state    <= ST_RD;
                     r_mem_read <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               if (r_cnt == LAST_CNT) begin
                  r_mem_read <= 1'b0;
                  if (r_write) begin
                     r_state          <= ST_WR;
                     r_mem_write      <= 1'b1;
                     r_mem_write_data <= w_merge;
                  end else begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_load;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_WR: begin
               r_mem_write  <= 1'b0;
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
            end
            ST_RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_error <= 1'b0;
               r_resp_rdata <= '0;
               r_ready      <= 1'b1;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign resp_valid     = r_resp_valid;
   assign resp_error     = r_resp_error;
   assign resp_rdata     = r_resp_rdata;
   assign mem_read       = r_mem_read;
   assign mem_write      = r_mem_write;
   assign mem_address    = r_mem_address;
   assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

   localparam int W = 2;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      int          lat;
      int          nrd;
      int          nwr;
      logic [63:0] idx;
      logic [63:0] wval;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_error;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic [63:0] mem_read_data;

   logic        mem_init;
   logic [63:0] mem_arr [64];
   logic [7:0]  ref_bytes [512];

   exp_t        exp_q[$];
   int          acc_q[$];
   int          total = 0;
   int          bad = 0;
   int          ncyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          n_resp = 0;

   load_store_unit #(
      .DATA_WIDTH(64), .ADDR_WIDTH(64), .MEM_INDEX_WIDTH(6), .WAIT_CYCLES(W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_error     (resp_error),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] init_word(input int i);
      return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'hC3A5_5A3C};
   endfunction

   // Data memory: combinational read, write committed at the edge mem_write is seen.
   assign mem_read_data = mem_arr[mem_address[5:0]];
   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
      end else if (mem_write) begin
         mem_arr[mem_address[5:0]] <= mem_write_data;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, expv);
      end
   endtask

   function automatic logic [63:0] ref_dword(input int idx);
      logic [63:0] v;
      v = '0;
      for (int b = 0; b < 8; b++) v[8*b +: 8] = ref_bytes[idx*8 + b];
      return v;
   endfunction

   // Monitor: sample at the falling edge, match responses and strobes against the queue head.
   always @(negedge clock) begin
      exp_t e;
      int   a;
      if (reset) begin
         acc_q.delete();
         rd_cnt = 0;
         wr_cnt = 0;
      end else begin
         ncyc++;
         if (mem_read || mem_write) chk("strobe_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
         if (mem_read) begin
            rd_cnt++;
            if (exp_q.size() > 0) chk("rd_addr", mem_address, exp_q[0].idx);
         end
         if (mem_write) begin
            wr_cnt++;
            if (exp_q.size() > 0) begin
               chk("wr_addr", mem_address, exp_q[0].idx);
               chk("wr_data", mem_write_data, exp_q[0].wval);
            end
         end
         if (resp_valid) begin
            n_resp++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("resp_error", {63'd0, resp_error}, {63'd0, e.err});
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("latency", 64'(ncyc - a), 64'(e.lat));
               chk("rd_cycles", 64'(rd_cnt), 64'(e.nrd));
               chk("wr_cycles", 64'(wr_cnt), 64'(e.nwr));
            end
         end
         if (req_valid && req_ready) begin
            acc_q.push_back(ncyc);
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   // Computes the expected outcome from byte-level rules, then drives the request until accepted.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd);
      exp_t        e;
      int          nb;
      int          base;
      logic [63:0] v;
      logic        ok;
      nb = 1 << sz;
      e.err = 1'b0; e.rdata = '0; e.lat = 0; e.nrd = 0; e.nwr = 0; e.wval = '0;
      e.idx = addr >> 3;
      if ((addr % 64'(nb)) != 0 || addr >= 64'd512) begin
         e.err = 1'b1;
         e.lat = 1;
      end else if (wr) begin
         base = int'(addr[8:0]);
         for (int i = 0; i < nb; i++) ref_bytes[base + i] = wd[8*i +: 8];
         e.wval = ref_dword(base / 8);
         e.nwr  = 1;
         e.nrd  = (nb == 8) ? 0 : W;
         e.lat  = (nb == 8) ? 2 : W + 2;
      end else begin
         base = int'(addr[8:0]);
         v = '0;
         for (int i = 0; i < nb; i++) v = v | (64'(ref_bytes[base + i]) << (8*i));
         if (sg && nb < 8 && v[8*nb-1]) v = v | ({64{1'b1}} << (8*nb));
         e.rdata = v;
         e.nrd   = W;
         e.lat   = W + 1;
      end
      exp_q.push_back(e);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clock);
      #1;
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = {$urandom, $urandom};
      req_wdata  = {$urandom, $urandom};
   endtask

   initial begin
      logic [63:0] w0;
      logic [63:0] addr;
      logic [1:0]  sz;
      int          r;
      int          n0;
      for (int i = 0; i < 64; i++) begin
         w0 = init_word(i);
         for (int b = 0; b < 8; b++) ref_bytes[i*8 + b] = w0[8*b +: 8];
      end

      reset = 1'b1; mem_init = 1'b1; req_valid = 1'b1;
      req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0;
      req_addr = 64'h18; req_wdata = 64'hDEAD_BEEF_0000_1111;
      @(posedge clock); #1;
      mem_init = 1'b0;
      @(negedge clock);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_error", {63'd0, resp_error}, 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
      chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
      chk("rst_mem_address", mem_address, 64'd0);
      chk("rst_mem_write_data", mem_write_data, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clock);
      chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
      @(posedge clock); #1;

      do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122_3344_5566_7788);
      do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'h0);
      do_req(1'b1, 2'd1, 1'b0, 64'h1A, 64'h0000_0000_0000_ABCD);
      do_req(1'b0, 2'd3, 1'b0, 64'h18, 64'h0);
      do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122_3344_5566_7788);
      do_req(1'b0, 2'd2, 1'b0, 64'h1C, 64'h0);
      do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h8011_2233_4455_6677);
      do_req(1'b0, 2'd0, 1'b1, 64'h1F, 64'h0);
      do_req(1'b0, 2'd0, 1'b0, 64'h1F, 64'h0);
      do_req(1'b0, 2'd2, 1'b0, 64'h1E, 64'h0);
      do_req(1'b0, 2'd3, 1'b0, 64'h200, 64'h0);
      do_req(1'b1, 2'd0, 1'b0, 64'h200, 64'h55);

      // Reset while the load is in its read phase: no response may follow.
      repeat (6) @(posedge clock);
      #1;
      do_req(1'b0, 2'd3, 1'b1, 64'h40, 64'h0);
      reset = 1'b1;
      exp_q.delete();
      n0 = n_resp;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("ready_after_mid_reset", {63'd0, req_ready}, 64'd1);
      repeat (6) @(negedge clock);
      chk("no_resp_after_mid_reset", 64'(n_resp - n0), 64'd0);
      @(posedge clock); #1;

      for (int k = 0; k < 250; k++) begin
         sz = 2'($urandom);
         r = int'($urandom_range(0, 15));
         if (r == 0) addr = 64'd512 + 64'($urandom_range(0, 1023));
         else if (r == 1) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
         else addr = 64'($urandom_range(0, 511));
         if (r > 3) addr = addr & ~(64'(1 << sz) - 64'd1);
         do_req(1'($urandom), sz, 1'($urandom), addr, {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end

      for (int c = 0; c < 50 && exp_q.size() > 0; c++) @(negedge clock);
      chk("drain_pending", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
